// File: rtl/repeat_pulse_accel.sv
// N-channel press-and-hold pulse generator: one pulse per press, then an optional
// auto-repeat whose period halves every HOLD_CYCLES until it reaches MIN_PERIOD.
module repeat_pulse_accel #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 28,
    parameter int START_PERIOD = 100000000,
    parameter int MIN_PERIOD   = 6250000,
    parameter int HOLD_CYCLES  = 200000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] level,
    input  logic            mode,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] fast
);

    localparam logic [CNT_W-1:0] START_P   = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic {
        IDLE,
        HELD
    } state_e;

    typedef struct packed {
        state_e            state;
        logic [CNT_W-1:0]  rep_cnt;
        logic [CNT_W-1:0]  hold_cnt;
        logic [CNT_W-1:0]  period;
    } ch_t;

    ch_t             ch_q [N_CH];
    ch_t             ch_d [N_CH];
    logic [N_CH-1:0] level_prev_q;
    logic [N_CH-1:0] pulse_q, pulse_d;
    logic [N_CH-1:0] fast_q, fast_d;

    always_comb begin
        logic [CNT_W-1:0] halved;
        // NOTE: every combinational output gets a default before any branch, so no path infers a latch.
        ch_d    = ch_q;
        pulse_d = '0;
        fast_d  = '0;
        halved  = '0;
        for (int i = 0; i < N_CH; i++) begin
            halved = ch_q[i].period >> 1;
            case (ch_q[i].state)
                IDLE: begin
                    if (level[i] && !level_prev_q[i]) begin
                        ch_d[i].state    = HELD;
                        ch_d[i].rep_cnt  = '0;
                        ch_d[i].hold_cnt = '0;
                        ch_d[i].period   = START_P;
                        pulse_d[i]       = 1'b1;
                    end
                end
                HELD: begin
                    if (!level[i]) begin
                        ch_d[i].state    = IDLE;
                        ch_d[i].rep_cnt  = '0;
                        ch_d[i].hold_cnt = '0;
                        ch_d[i].period   = START_P;
                    end else if (!mode) begin
                        // Repeat disabled: park at press values so re-enabling starts fresh.
                        ch_d[i].rep_cnt  = '0;
                        ch_d[i].hold_cnt = '0;
                        ch_d[i].period   = START_P;
                    end else begin
                        // ">=" lets a counter left above a freshly halved period fire at once.
                        if (ch_q[i].rep_cnt >= ch_q[i].period - ONE) begin
                            pulse_d[i]      = 1'b1;
                            ch_d[i].rep_cnt = '0;
                        end else begin
                            ch_d[i].rep_cnt = ch_q[i].rep_cnt + ONE;
                        end
                        if (ch_q[i].hold_cnt == HOLD_LAST) begin
                            ch_d[i].hold_cnt = '0;
                            ch_d[i].period   = (halved < MIN_P) ? MIN_P : halved;
                        end else begin
                            ch_d[i].hold_cnt = ch_q[i].hold_cnt + ONE;
                        end
                    end
                end
                default: ch_d[i].state = IDLE;
            endcase
            fast_d[i] = (ch_d[i].state == HELD) && (ch_d[i].period == MIN_P);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                ch_q[i].state    <= IDLE;
                ch_q[i].rep_cnt  <= '0;
                ch_q[i].hold_cnt <= '0;
                ch_q[i].period   <= START_P;
            end
            // All-ones history: a button held through reset must be released before it counts.
            level_prev_q <= '1;
            pulse_q      <= '0;
            fast_q       <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                ch_q[i] <= ch_d[i];
            end
            level_prev_q <= level;
            pulse_q      <= pulse_d;
            fast_q       <= fast_d;
        end
    end

    assign pulse = pulse_q;
    assign fast  = fast_q;

endmodule

// File: tb/tb_repeat_pulse_accel.sv
// Self-checking bench for repeat_pulse_accel: fixed vectors, scheduled scenarios
// and random stimulus against an arithmetic press-age reference model.
module tb_repeat_pulse_accel;

    localparam int N_CH  = 2;
    localparam int START = 8;
    localparam int MINP  = 2;
    localparam int HOLD  = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] level = '0;
    logic            mode = 1'b1;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] fast;

    repeat_pulse_accel #(
        .N_CH(N_CH), .CNT_W(8), .START_PERIOD(START),
        .MIN_PERIOD(MINP), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .level(level), .mode(mode),
        .pulse(pulse), .fast(fast)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int first_fast0 = -1;
    int p0_q[$];
    int p1_q[$];

    // Reference model: age = edges since repeating (re)started; period in force after
    // age a is max(START >> (a / HOLD), MIN); a pulse fires once the gap since the last
    // pulse reaches the period that was in force on the previous edge.
    bit              m_held [N_CH];
    int              m_age  [N_CH];
    int              m_last [N_CH];
    logic [N_CH-1:0] m_prev  = '1;
    logic [N_CH-1:0] m_pulse = '0;
    logic [N_CH-1:0] m_fast  = '0;

    function automatic int per_at(input int a);
        int s = a / HOLD;
        int p = (s >= 31) ? 0 : (START >> s);
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_update(input logic r, input logic [N_CH-1:0] lv, input logic md);
        m_pulse = '0;
        m_fast  = '0;
        if (r) begin
            m_prev = '1;
            for (int i = 0; i < N_CH; i++) m_held[i] = 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!m_held[i]) begin
                    if (lv[i] && !m_prev[i]) begin
                        m_held[i] = 1'b1; m_age[i] = 0; m_last[i] = 0; m_pulse[i] = 1'b1;
                    end
                end else if (!lv[i]) begin
                    m_held[i] = 1'b0;
                end else if (!md) begin
                    m_age[i] = 0; m_last[i] = 0;
                end else begin
                    m_age[i]++;
                    if (m_age[i] - m_last[i] >= per_at(m_age[i] - 1)) begin
                        m_pulse[i] = 1'b1; m_last[i] = m_age[i];
                    end
                end
                m_fast[i] = m_held[i] && (per_at(m_age[i]) == MINP);
            end
            m_prev = lv;
        end
    endtask

    task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic [N_CH-1:0] lv, input logic md);
        @(negedge clk);
        rst = r; level = lv; mode = md;
        @(posedge clk);
        model_update(r, lv, md);
        cyc++;
        #1;
        check("pulse_vs_model", pulse, m_pulse);
        check("fast_vs_model", fast, m_fast);
        if (pulse[0]) p0_q.push_back(cyc);
        if (pulse[1]) p1_q.push_back(cyc);
        if (fast[0] && first_fast0 < 0) first_fast0 = cyc;
    endtask

    task automatic reset_seq();
        tick(1'b1, '0, 1'b1);
        tick(1'b1, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        p0_q.delete(); p1_q.delete(); first_fast0 = -1;
    endtask

    function automatic int off_at(input int q[$], input int i, input int base);
        return (i < q.size()) ? q[i] - base : -1;
    endfunction

    typedef struct {
        logic            rst;
        logic [N_CH-1:0] level;
        logic            mode;
        logic [N_CH-1:0] exp_pulse;
        logic [N_CH-1:0] exp_fast;
    } vec_t;

    vec_t vecs[13];
    int   exp_a0[13] = '{0, 8, 16, 21, 25, 29, 33, 37, 41, 43, 45, 47, 49};
    int   exp_a1[11] = '{5, 13, 21, 26, 30, 34, 38, 42, 46, 48, 50};
    int   exp_b0[4]  = '{0, 8, 15, 23};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, m, bad, nf;
        logic [N_CH-1:0] lv;
        logic md, r;

        vecs[0]  = '{1'b1, 2'b11, 1'b1, 2'b00, 2'b00};
        vecs[1]  = '{1'b0, 2'b11, 1'b1, 2'b00, 2'b00};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 2'b00, 2'b00};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 2'b01, 2'b00};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 2'b00, 2'b00};
        vecs[5]  = '{1'b0, 2'b11, 1'b1, 2'b10, 2'b00};
        vecs[6]  = '{1'b0, 2'b10, 1'b1, 2'b00, 2'b00};
        vecs[7]  = '{1'b0, 2'b11, 1'b1, 2'b01, 2'b00};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 2'b00, 2'b00};
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 2'b10, 2'b00};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 2'b00, 2'b00};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 2'b00, 2'b00};

        for (int v = 0; v < 13; v++) begin
            tick(vecs[v].rst, vecs[v].level, vecs[v].mode);
            check($sformatf("vec%0d_pulse", v), pulse, vecs[v].exp_pulse);
            check($sformatf("vec%0d_fast", v), fast, vecs[v].exp_fast);
        end

        // Acceleration on ch0, with ch1 pressed 5 edges later.
        reset_seq();
        tick(1'b0, 2'b01, 1'b1); k = cyc;
        for (int t = 1; t <= 50; t++) tick(1'b0, {t >= 5, 1'b1}, 1'b1);
        check_int("accel_ch0_count", p0_q.size(), 13);
        for (int i = 0; i < 13; i++) check_int($sformatf("accel_ch0_p%0d", i), off_at(p0_q, i, k), exp_a0[i]);
        check_int("accel_ch1_count", p1_q.size(), 11);
        for (int i = 0; i < 11; i++) check_int($sformatf("indep_ch1_p%0d", i), off_at(p1_q, i, k), exp_a1[i]);
        check_int("fast_rise", first_fast0 - k, 40);

        // Saturation: 200 more held edges.
        p0_q.delete(); nf = 0; bad = 0;
        for (int t = 51; t <= 250; t++) begin
            tick(1'b0, 2'b11, 1'b1);
            if (!fast[0]) nf++;
        end
        check_int("sat_count", p0_q.size(), 100);
        check_int("sat_first", off_at(p0_q, 0, k), 51);
        for (int i = 1; i < p0_q.size(); i++) if (p0_q[i] - p0_q[i-1] != 2) bad++;
        check_int("sat_spacing_bad", bad, 0);
        check_int("sat_fast_low_cycles", nf, 0);

        // Release at k+12, re-press at k+15.
        reset_seq();
        tick(1'b0, 2'b01, 1'b1); k = cyc;
        for (int t = 1; t <= 30; t++) tick(1'b0, {1'b0, !(t >= 12 && t <= 14)}, 1'b1);
        check_int("repress_count", p0_q.size(), 4);
        for (int i = 0; i < 4; i++) check_int($sformatf("repress_p%0d", i), off_at(p0_q, i, k), exp_b0[i]);

        // Mode 0 hold, repeat enabled from edge k+51.
        reset_seq();
        tick(1'b0, 2'b10, 1'b0); k = cyc;
        for (int t = 1; t <= 60; t++) tick(1'b0, 2'b10, t > 50);
        check_int("mode0_count", p1_q.size(), 2);
        check_int("mode0_p0", off_at(p1_q, 0, k), 0);
        check_int("mode0_p1", off_at(p1_q, 1, k), 58);

        // Reset mid-hold.
        reset_seq();
        tick(1'b0, 2'b01, 1'b1); k = cyc;
        for (int t = 1; t <= 29; t++) tick(1'b0, 2'b01, 1'b1);
        p0_q.delete();
        tick(1'b1, 2'b01, 1'b1);
        check("rst_mid_pulse", pulse, 2'b00);
        check("rst_mid_fast", fast, 2'b00);
        for (int t = 0; t < 10; t++) tick(1'b0, 2'b01, 1'b1);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b01, 1'b1); m = cyc;
        for (int t = 0; t < 3; t++) tick(1'b0, 2'b01, 1'b1);
        check_int("rst_mid_count", p0_q.size(), 1);
        check_int("rst_mid_press", off_at(p0_q, 0, m), 0);

        // Random stimulus against the model.
        reset_seq();
        lv = '0; md = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < N_CH; i++) if ($urandom_range(15) == 0) lv[i] = ~lv[i];
            if ($urandom_range(63) == 0) md = ~md;
            r = ($urandom_range(255) == 0);
            tick(r, lv, md);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/repeat_pulse_accel.md
Name: repeat_pulse_accel

Overview:
- N-channel press-and-hold pulse generator for front-panel buttons; successor to the single-channel Gray-counter pulse block.
- Per channel: one single-cycle pulse on press. In repeat mode it then auto-repeats, and the repeat period halves every HOLD_CYCLES until it reaches MIN_PERIOD.
- Sits between the debounced button inputs and the counter/display logic; each pulse is one "step" event.

Parameters:
- N_CH, 4, number of independent button channels
- CNT_W, 28, width of all period/hold counters
- START_PERIOD, 100000000, initial repeat interval in clk cycles
- MIN_PERIOD, 6250000, floor for the repeat interval
- HOLD_CYCLES, 200000000, hold time between successive period halvings
- Legal: 1 <= MIN_PERIOD <= START_PERIOD < 2^CNT_W; 1 <= HOLD_CYCLES < 2^CNT_W

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- level  in  N_CH  debounced, already-synchronous button levels, 1 = pressed
- mode  in  1  0 = press-pulse only; 1 = press-pulse plus accelerating auto-repeat
- pulse  out  N_CH  registered single-cycle event per channel
- fast  out  N_CH  registered; 1 while channel is held and its period == MIN_PERIOD

Behaviour:
- Reset:
  - pulse=0, fast=0, all counters 0, period=START_PERIOD, state IDLE.
  - The level history register resets to all-1. A button held through reset produces no pulse; it must be released first.
- Per-channel state is independent; no sharing between channels.
- States: IDLE, HELD.
- IDLE -> HELD on the edge where level=1 and the previous sample was 0.
  - pulse=1 for the following cycle (latency 1).
  - rep_cnt=0, hold_cnt=0, period=START_PERIOD.
- HELD with level=1, mode=1, each edge:
  - rep_cnt: if rep_cnt >= period-1, pulse=1 and rep_cnt=0; else rep_cnt+1 and pulse=0.
  - hold_cnt: if hold_cnt == HOLD_CYCLES-1, hold_cnt=0 and period = max(period>>1, MIN_PERIOD) (floor shift); else hold_cnt+1.
  - Same-edge rep and hold events: the pulse decision uses the old period; the new period applies from the next edge.
  - The ">=" compare means a rep_cnt already past the new period fires on the next edge. No overflow or hang.
- HELD with level=1, mode=0: pulse=0; rep_cnt, hold_cnt and period held at their press values (0, 0, START_PERIOD).
  - A later mode 0->1 starts repeating fresh, with the first repeat START_PERIOD cycles later.
- HELD with level=0 -> IDLE on that edge: pulse=0, counters cleared, period=START_PERIOD, fast=0.
  - Re-press always restarts from START_PERIOD.
- fast is registered from the updated period: fast = HELD && period==MIN_PERIOD.
  - If START_PERIOD==MIN_PERIOD, fast=1 from the cycle after the press edge.
- Period saturates at MIN_PERIOD; later hold events leave it unchanged.
- pulse is never high for 2 consecutive cycles unless MIN_PERIOD==1.
- rst takes priority over all other activity on the same edge.

Test Plan (N_CH=2, START_PERIOD=8, MIN_PERIOD=2, HOLD_CYCLES=20, mode=1; press sampled at edge k):
- Acceleration: level[0] held from edge k.
  - pulse[0] high after edges k, k+8, k+16, k+21, k+25, k+29, k+33, k+37, k+41, k+43, k+45...
  - fast[0] rises after edge k+40.
- Release/re-press: release at k+12, re-press at k+15.
  - No pulse from the release.
  - Pulses after k+15 and k+23; period restarted at 8.
- Mode 0: mode=0, hold level[1] for 100 cycles -> exactly one pulse, after edge k. Switch mode=1 at k+50 -> next pulse after edge k+58.
- Channel independence: level[1] pressed at k+5 while ch0 is held -> ch1 pulses after k+5, k+13...; ch0 timing unchanged from the acceleration scenario.
- Reset mid-hold: rst at k+30 with level[0] still high -> pulse=0 and fast=0 after that edge; no pulse until release then press; press then yields a pulse one cycle later.
- Saturation: hold for 200 cycles -> spacing stays 2, fast stays 1, no consecutive-cycle pulses.
